reg_track: RTL and testbench
============================

Name: reg_track

Overview:
- Pipeline register scoreboard for the 5-stage core (IF/ID/EX/MEM/WB, 8 GPRs r0–r7).
- Records every register-writing instruction issued into ID/EX and follows it through EX, MEM and WB.
- Each cycle, produces a per-register 3-bit status `register_invalid` consumed by the decode-stage controller:
  - 1 = stall.
  - 2 = forward from EX/MEM.
  - 3 = forward from MEM/WB.
- Sits directly upstream of the controller and closes the loop with the controller's `regwrite_cur`.

Parameters:
- NREG, 8, number of architectural registers; index width is $clog2(NREG) = 3.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- regwrite_cur  input  1  the instruction in ID is really issued into ID/EX this cycle and writes a register (already gated by en_idex/flush_idex).
- regwrite_adr_id  input  3  destination register of the issuing instruction.
- from_main_mem_id  input  1  issuing instruction is a load; result only exists after MEM.
- en_idex  input  1  ID/EX register enable.
- en_exmem  input  1  EX/MEM register enable.
- flush_exmem  input  1  EX/MEM register cleared this cycle.
- en_memwb  input  1  MEM/WB register enable.
- flush_memwb  input  1  MEM/WB register cleared this cycle.
- register_invalid  output  3 x [7:0] (unpacked array)  per-register status code.

Behaviour:
- State: three slots, ex_s, mem_s and wb_s, mirroring ID/EX, EX/MEM and MEM/WB.
  - Each slot holds {valid, dst[2:0], is_load}.
- Reset (rst_n low, asynchronous): all slot valid bits = 0. Consequently every register_invalid[i] = 0 while in reset and on the first cycle after.
- Slot update on each rising clk:
  - ex_s: if en_idex, loads {regwrite_cur, regwrite_adr_id, from_main_mem_id}; else holds.
  - mem_s: if flush_exmem, valid = 0; else if en_exmem, takes ex_s; else holds.
  - wb_s: if flush_memwb, valid = 0; else if en_memwb, takes mem_s; else holds.
  - An entry leaving wb_s retires. The register file is written on that same edge, so the code returns to 0.
- Flush priority: flush beats enable. A flush on the same edge as an issue still loads the new ex_s entry, because regwrite_cur is already 0 when ID/EX is flushed.
- Status code per register i, combinational from the slots only, with youngest-match priority ex_s > mem_s > wb_s:
  - Match in ex_s: 1 (result not yet in any pipeline register).
  - Else match in mem_s: 1 if is_load (EX/MEM holds the address, not the data); else 2.
  - Else match in wb_s: 3.
  - Else: 0.
- Multiple slots may hold the same dst. Only the youngest valid one decides.
- Latency: an issue at edge N is visible as 1 in cycle N+1, then moves one stage per enabled edge.
  - ALU producer: 1, 2, 3, 0.
  - Load producer: 1, 1, 3, 0.
- Stall interaction: when the controller stalls, regwrite_cur = 0 while en_idex = 1, so a bubble enters ex_s. Older entries keep advancing.
- Reset asserted mid-operation clears all slots immediately; no stale codes remain after deassert.

Optional Feature:
- Macro: REG_TRACK_PERF_EN.
- Defined:
  - Extra output hazard_cycles [15:0], reset 0.
  - Increments by 1 on each clk where any register_invalid[i] == 1; saturates at 16'hFFFF.
  - Extra output inflight [1:0], the count of valid slots capped at 3, combinational.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package reg_track_pkg:
  - Code constants RI_NONE=0, RI_STALL=1, RI_FWD_EXMEM=2, RI_FWD_MEMWB=3.
  - typedef ri_code_t (logic [2:0]).
  - typedef struct track_slot_t {valid, dst, is_load}.
- Sub-module reg_track_encode: purely combinational. Takes the three slots and one register index and returns that register's ri_code_t. Instantiated NREG times in a generate loop.
- Slot registers and the perf counter stay in reg_track.

Test Plan:
- Reset with stale slots, then release: all 8 codes = 0 during reset and the next cycle.
- Issue ADD to r3 (regwrite_cur=1, adr=3, load=0), then bubbles: r3 codes over 4 cycles = 1, 2, 3, 0; all others stay 0.
- Issue LD to r5, then bubbles: r5 codes = 1, 1, 3, 0.
- Back-to-back writes r2(ALU) then r2(LD): cycle 2 shows 1 (ex_s load wins over mem_s ALU); cycle 3 shows 1 (mem_s load wins over wb_s); cycle 4 shows 3; cycle 5 shows 0.
- ALU to r4 issued, next edge flush_exmem=1: r4 goes 1 → 0 (entry killed).
- Same flow with flush_memwb instead: r4 goes 1 → 2 → 0 (entry killed).
- REG_TRACK_PERF_EN defined, LD r1 followed by 2 bubbles: hazard_cycles = 2; with hazard_cycles preloaded near max, 70000 stall cycles give 16'hFFFF.

Source files
------------

// File: rtl/reg_track_pkg.sv
// reg_track_pkg: shared types and constants for the pipeline register scoreboard.
//   NREG / IDXW   : architectural register count and index width
//   ri_code_t     : per-register status code seen by the decode controller
//   track_slot_t  : one tracked pipeline slot {valid, dst, is_load}
package reg_track_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned IDXW = $clog2(NREG);

    typedef logic [2:0] ri_code_t;

    localparam ri_code_t RI_NONE      = 3'd0;
    localparam ri_code_t RI_STALL     = 3'd1;
    localparam ri_code_t RI_FWD_EXMEM = 3'd2;
    localparam ri_code_t RI_FWD_MEMWB = 3'd3;

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] dst;
        logic            is_load;
    } track_slot_t;

endpackage

// File: rtl/reg_track_if.sv
// reg_track_if: issue/pipeline-control inputs and status outputs of reg_track.
//   master : decode-stage controller side (drives issue + pipeline control)
//   slave  : reg_track side (returns register_invalid)
interface reg_track_if;
    import reg_track_pkg::*;

    logic            regwrite_cur;
    logic [IDXW-1:0] regwrite_adr_id;
    logic            from_main_mem_id;
    logic            en_idex;
    logic            en_exmem;
    logic            flush_exmem;
    logic            en_memwb;
    logic            flush_memwb;
    ri_code_t        register_invalid [NREG];

    modport master (
        output regwrite_cur, regwrite_adr_id, from_main_mem_id,
        output en_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        input  register_invalid
    );

    modport slave (
        input  regwrite_cur, regwrite_adr_id, from_main_mem_id,
        input  en_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        output register_invalid
    );

endinterface

// File: rtl/reg_track_encode.sv
// reg_track_encode: combinational status code for one register.
//   ex_i, mem_i, wb_i : tracked slots (ID/EX, EX/MEM, MEM/WB)
//   idx_i             : register index being evaluated
//   code_o            : status code; youngest matching slot decides
module reg_track_encode
    import reg_track_pkg::*;
(
    input  track_slot_t     ex_i,
    input  track_slot_t     mem_i,
    input  track_slot_t     wb_i,
    input  logic [IDXW-1:0] idx_i,
    output ri_code_t        code_o
);

    always_comb begin
        code_o = RI_NONE;
        if (ex_i.valid && (ex_i.dst == idx_i)) begin
            code_o = RI_STALL;
        end else if (mem_i.valid && (mem_i.dst == idx_i)) begin
            // A load in EX/MEM only carries the address, so it cannot forward yet.
            code_o = mem_i.is_load ? RI_STALL : RI_FWD_EXMEM;
        end else if (wb_i.valid && (wb_i.dst == idx_i)) begin
            code_o = RI_FWD_MEMWB;
        end
    end

endmodule

// File: rtl/reg_track.sv
// reg_track: follows register-writing instructions through EX, MEM and WB and
// reports a per-register hazard status to the decode-stage controller.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   bus (slave)   : issue info, pipeline enables/flushes, register_invalid
// Optional (macro REG_TRACK_PERF_EN):
//   hazard_cycles : saturating count of cycles with any stall code
//   inflight      : number of valid tracked slots
module reg_track
    import reg_track_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
`ifdef REG_TRACK_PERF_EN
    output logic [15:0] hazard_cycles,
    output logic [1:0]  inflight,
`endif
    reg_track_if.slave  bus
);

    track_slot_t ex_q, ex_d;
    track_slot_t mem_q, mem_d;
    track_slot_t wb_q, wb_d;
    ri_code_t    codes [NREG];

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;

        if (bus.en_idex) begin
            ex_d.valid   = bus.regwrite_cur;
            ex_d.dst     = bus.regwrite_adr_id;
            ex_d.is_load = bus.from_main_mem_id;
        end

        if (bus.flush_exmem) begin
            mem_d.valid = 1'b0;
        end else if (bus.en_exmem) begin
            mem_d = ex_q;
        end

        // Leaving wb_q retires the entry: the register file is written on this edge.
        if (bus.flush_memwb) begin
            wb_d.valid = 1'b0;
        end else if (bus.en_memwb) begin
            wb_d = mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_enc
        reg_track_encode u_enc (
            .ex_i   (ex_q),
            .mem_i  (mem_q),
            .wb_i   (wb_q),
            .idx_i  (IDXW'(g)),
            .code_o (codes[g])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            bus.register_invalid[i] = codes[i];
        end
    end

`ifdef REG_TRACK_PERF_EN
    logic        any_stall;
    logic [15:0] hazard_q;

    always_comb begin
        any_stall = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (codes[i] == RI_STALL) begin
                any_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_q <= '0;
        end else if (any_stall && (hazard_q != '1)) begin
            hazard_q <= hazard_q + 16'd1;
        end
    end

    assign hazard_cycles = hazard_q;
    // Three slots at most, so the sum never exceeds the 2-bit range.
    assign inflight = 2'(ex_q.valid) + 2'(mem_q.valid) + 2'(wb_q.valid);
`endif

endmodule

// File: tb/tb_reg_track.sv
module tb_reg_track;
    import reg_track_pkg::*;

    logic clk;
    logic rst_n;

    reg_track_if ifc ();

`ifdef REG_TRACK_PERF_EN
    logic [15:0] hazard_cycles;
    logic [1:0]  inflight;
`endif

    reg_track dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef REG_TRACK_PERF_EN
        .hazard_cycles (hazard_cycles),
        .inflight      (inflight),
`endif
        .bus           (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        string       tag;
        logic [23:0] exp;
    } sb_t;

    sb_t sbq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] dut_vec();
        logic [23:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t[3*i +: 3] = ifc.register_invalid[i];
        return t;
    endfunction

    function automatic logic [23:0] v1(input int r, input logic [2:0] c);
        logic [23:0] t;
        t = '0;
        t[3*r +: 3] = c;
        return t;
    endfunction

    task automatic idle_inputs();
        ifc.regwrite_cur     = 1'b0;
        ifc.regwrite_adr_id  = 3'd0;
        ifc.from_main_mem_id = 1'b0;
        ifc.en_idex          = 1'b1;
        ifc.en_exmem         = 1'b1;
        ifc.flush_exmem      = 1'b0;
        ifc.en_memwb         = 1'b1;
        ifc.flush_memwb      = 1'b0;
    endtask

    task automatic issue(input logic [2:0] adr, input logic ld);
        ifc.regwrite_cur     = 1'b1;
        ifc.regwrite_adr_id  = adr;
        ifc.from_main_mem_id = ld;
    endtask

    // Push expectation, clock one edge, then pop and compare against the DUT.
    task automatic step(input string tag, input logic [23:0] exp);
        sb_t e;
        sbq.push_back('{tag, exp});
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        e = sbq.pop_front();
        check_eq(e.tag, 32'(dut_vec()), 32'(e.exp));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_hold", 32'(dut_vec()), 32'd0);
        rst_n = 1'b1;
        step("rst_first", 24'd0);

        // ALU to r3: 1, 2, 3, 0
        issue(3'd3, 1'b0);
        step("add_c1", v1(3, 1));
        step("add_c2", v1(3, 2));
        step("add_c3", v1(3, 3));
        step("add_c4", 24'd0);

        // Load to r5: 1, 1, 3, 0
        issue(3'd5, 1'b1);
        step("ld_c1", v1(5, 1));
        step("ld_c2", v1(5, 1));
        step("ld_c3", v1(5, 3));
        step("ld_c4", 24'd0);

        // r2 ALU then r2 LD: youngest match wins
        issue(3'd2, 1'b0);
        step("dup_c1", v1(2, 1));
        issue(3'd2, 1'b1);
        step("dup_c2", v1(2, 1));
        step("dup_c3", v1(2, 1));
        step("dup_c4", v1(2, 3));
        step("dup_c5", 24'd0);

        // flush_exmem kills r4 while moving EX -> MEM
        issue(3'd4, 1'b0);
        step("fxm_c1", v1(4, 1));
        ifc.flush_exmem = 1'b1;
        step("fxm_c2", 24'd0);
        step("fxm_c3", 24'd0);

        // flush_memwb kills r4 while moving MEM -> WB
        issue(3'd4, 1'b0);
        step("fmw_c1", v1(4, 1));
        step("fmw_c2", v1(4, 2));
        ifc.flush_memwb = 1'b1;
        step("fmw_c3", 24'd0);

        // Three producers in flight on different registers
        issue(3'd0, 1'b0);
        step("mix_c1", v1(0, 1));
        issue(3'd7, 1'b1);
        step("mix_c2", v1(7, 1) | v1(0, 2));
        issue(3'd6, 1'b0);
        step("mix_c3", v1(6, 1) | v1(7, 1) | v1(0, 3));
        step("mix_c4", v1(6, 2) | v1(7, 3));
        step("mix_c5", v1(6, 3));
        step("mix_c6", 24'd0);

        // All enables low: entry holds in place
        issue(3'd1, 1'b0);
        step("hold_c1", v1(1, 1));
        ifc.en_idex = 1'b0; ifc.en_exmem = 1'b0; ifc.en_memwb = 1'b0;
        step("hold_c2", v1(1, 1));
        ifc.en_idex = 1'b0; ifc.en_exmem = 1'b0; ifc.en_memwb = 1'b0;
        step("hold_c3", v1(1, 1));
        step("hold_c4", v1(1, 2));
        step("hold_c5", v1(1, 3));
        step("hold_c6", 24'd0);

        // Asynchronous reset mid-operation with live slots
        issue(3'd3, 1'b0);
        step("rmid_c1", v1(3, 1));
        issue(3'd5, 1'b1);
        step("rmid_c2", v1(5, 1) | v1(3, 2));
        #2 rst_n = 1'b0;
        #1 check_eq("rmid_async", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        check_eq("rmid_held", 32'(dut_vec()), 32'd0);
        rst_n = 1'b1;
        step("rmid_rel1", 24'd0);
        step("rmid_rel2", 24'd0);

`ifdef REG_TRACK_PERF_EN
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("perf_rst", 32'(hazard_cycles), 32'd0);
        rst_n = 1'b1;
        issue(3'd1, 1'b1);
        step("perf_c1", v1(1, 1));
        check_eq("perf_infl1", 32'(inflight), 32'd1);
        step("perf_c2", v1(1, 1));
        step("perf_c3", v1(1, 3));
        check_eq("perf_haz2", 32'(hazard_cycles), 32'd2);
        check_eq("perf_infl2", 32'(inflight), 32'd1);
        issue(3'd6, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        @(negedge clk);
        check_eq("perf_sat", 32'(hazard_cycles), 32'hFFFF);
        check_eq("perf_infl3", 32'(inflight), 32'd3);
        idle_inputs();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
